// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg : shared FSM state encoding and counter sizing for the adder lab
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  // A single-digit operation still needs a one-bit counter register.
  function automatic int cnt_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
// ----------------------------------------------------------------------------
// digit_serial_adder_if : operand/result valid-ready bundle of the serial adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/digit_adder.sv
// ----------------------------------------------------------------------------
// digit_adder : combinational DIGIT-bit ripple adder of full_adder cells
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module digit_adder #(
  parameter int DIGIT = 2
) (
  input  wire  [DIGIT-1:0] x,
  input  wire  [DIGIT-1:0] y,
  input  wire              ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    full_adder u_fa (
      .i_a (x[gi]),
      .i_b (y[gi]),
      .i_c (w_c[gi]),
      .o_s (s[gi]),
      .o_c (w_c[gi+1])
    );
  end

  assign co    = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];
endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder : one-bit full adder cell
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  wire  i_a,
  input  wire  i_b,
  input  wire  i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// ----------------------------------------------------------------------------
// digit_serial_adder : WIDTH-bit add/subtract, DIGIT bits per clock, valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input wire               clk,
  input wire               rst,
  digit_serial_adder_if.slave bus
);
  localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] c_LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("digit_serial_adder: DIGIT=%0d illegal for WIDTH=%0d", DIGIT, WIDTH);
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  int               w_base;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;

  assign w_base = int'(r_cnt) * DIGIT;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (r_a[w_base +: DIGIT]),
    .y     (r_b[w_base +: DIGIT]),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1; the +1 rides in on the carry register.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: DIGIT] <= w_s;
          r_carry                <= w_co;
          if (r_cnt == c_LAST) begin
            r_cout  <= w_co;
            r_ovf   <= w_co ^ w_cmsb;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_digit_serial_adder : vector table, corner sequences and DIGIT sweep
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_digit_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    string      name;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_sw;
  int   checks;
  int   errors;
  int   sweep_done;

  vec_t vecs [9];
  exp_t sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(8)) dif ();

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    exp_t e;
    dif.a        = v.a;
    dif.b        = v.b;
    dif.cin      = v.cin;
    dif.sub      = v.sub;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    // Scramble the ports: the DUT must be working from its latched copies.
    dif.a   = 8'($urandom);
    dif.b   = 8'($urandom);
    dif.cin = ~v.cin;
    dif.sub = ~v.sub;
    e.sum  = v.sum;
    e.cout = v.cout;
    e.ovf  = v.ovf;
    sb.push_back(e);
    chk({v.name, " in_ready busy"}, 32'(dif.in_ready), 32'd0);
    lat = 0;
    while (!dif.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({v.name, " latency"}, lat, 4);
    chk({v.name, " in_ready at out_valid"}, 32'(dif.in_ready), 32'd0);
    e = sb.pop_front();
    chk({v.name, " sum"},  32'(dif.sum),  32'(e.sum));
    chk({v.name, " cout"}, 32'(dif.cout), 32'(e.cout));
    chk({v.name, " ovf"},  32'(dif.ovf),  32'(e.ovf));
    tick();
    chk({v.name, " out_valid after hs"}, 32'(dif.out_valid), 32'd0);
    chk({v.name, " in_ready after hs"},  32'(dif.in_ready),  32'd1);
  endtask

  initial begin
    int   lat;
    int   w;
    exp_t e;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add 0f+01"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add ff+01"};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add 7f+00+1"};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub 05-07"};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01"};
    vecs[5] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub cin ignored"};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add aa+55+1"};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "sub 00-00"};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "add 12+34"};

    checks        = 0;
    errors        = 0;
    sweep_done    = 0;
    rst           = 1'b1;
    rst_sw        = 1'b1;
    dif.in_valid  = 1'b0;
    dif.a         = 8'h00;
    dif.b         = 8'h00;
    dif.cin       = 1'b0;
    dif.sub       = 1'b0;
    dif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    rst_sw = 1'b0;

    chk("reset in_ready",  32'(dif.in_ready),  32'd1);
    chk("reset out_valid", 32'(dif.out_valid), 32'd0);
    chk("reset sum",       32'(dif.sum),       32'd0);
    chk("reset cout",      32'(dif.cout),      32'd0);
    chk("reset ovf",       32'(dif.ovf),       32'd0);

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Backpressure: result frozen, new operands refused while DONE.
    dif.out_ready = 1'b0;
    dif.a = 8'h0F; dif.b = 8'h01; dif.cin = 1'b0; dif.sub = 1'b0;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    sb.push_back('{8'h10, 1'b0, 1'b0});
    lat = 0;
    while (!dif.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp latency", lat, 4);
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      dif.in_valid = 1'b1;
      dif.a = 8'h11; dif.b = 8'h22;
      tick();
      chk("bp sum stable",  32'(dif.sum),       32'(e.sum));
      chk("bp cout stable", 32'(dif.cout),      32'(e.cout));
      chk("bp ovf stable",  32'(dif.ovf),       32'(e.ovf));
      chk("bp in_ready",    32'(dif.in_ready),  32'd0);
      chk("bp out_valid",   32'(dif.out_valid), 32'd1);
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    chk("bp hs out_valid", 32'(dif.out_valid), 32'd0);
    chk("bp hs in_ready",  32'(dif.in_ready),  32'd1);
    tick();
    chk("bp no stray accept", 32'(dif.in_ready), 32'd1);

    // Reset sampled at the second RUN edge aborts the operation.
    dif.a = 8'h0F; dif.b = 8'h01; dif.cin = 1'b0; dif.sub = 1'b0;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready",  32'(dif.in_ready),  32'd1);
    chk("abort out_valid", 32'(dif.out_valid), 32'd0);
    chk("abort sum",       32'(dif.sum),       32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort no out_valid", 32'(dif.out_valid), 32'd0);
    end
    run_op(vecs[8]);

    w = 0;
    while (sweep_done != 3 && w < 60000) begin
      @(posedge clk);
      w++;
    end
    chk("sweep completed", sweep_done, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int D  = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
    localparam int ND = 8 / D;

    digit_serial_adder_if #(.WIDTH(8)) sif ();

    digit_serial_adder #(.WIDTH(8), .DIGIT(D)) u_dut (
      .clk (clk),
      .rst (rst_sw),
      .bus (sif.slave)
    );

    exp_t q [$];

    initial begin
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] bb;
      logic       vcin;
      logic       vsub;
      logic       ci;
      logic [8:0] full;
      exp_t       e;
      int         lat;

      sif.in_valid  = 1'b0;
      sif.a         = 8'h00;
      sif.b         = 8'h00;
      sif.cin       = 1'b0;
      sif.sub       = 1'b0;
      sif.out_ready = 1'b1;
      wait (rst_sw == 1'b0);
      tick();
      for (int n = 0; n < 1000; n++) begin
        va   = 8'($urandom);
        vb   = 8'($urandom);
        vcin = 1'($urandom);
        vsub = 1'($urandom);
        bb   = vsub ? ~vb : vb;
        ci   = vsub ? 1'b1 : vcin;
        full = {1'b0, va} + {1'b0, bb} + 9'(ci);
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (va[7] == bb[7]) && (full[7] != va[7]);
        sif.a = va; sif.b = vb; sif.cin = vcin; sif.sub = vsub;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        sif.a = 8'($urandom);
        sif.b = 8'($urandom);
        q.push_back(e);
        lat = 0;
        while (!sif.out_valid && lat < 40) begin
          tick();
          lat++;
        end
        chk($sformatf("sweep D%0d latency", D), lat, ND);
        e = q.pop_front();
        chk($sformatf("sweep D%0d %h%s%h", D, va, vsub ? "-" : "+", vb),
            32'({sif.cout, sif.ovf, sif.sum}), 32'({e.cout, e.ovf, e.sum}));
        tick();
      end
      sweep_done++;
    end
  end

endmodule

`default_nettype wire
